mips_multi: RTL and testbench

Multicycle MIPS core with a single unified memory port; the next generation after the single-cycle core. One instruction executes over 3-5 states of a control FSM, sharing one ALU and one memory interface for fetch and data. Memory latency is variable via a `memready` handshake. Compared with the single-cycle core it adds `andi`, `slti`, a parametrised reset vector, and a halt-on-illegal-opcode state. It sits under the memory/top wrapper in place of the single-cycle core.

---
 rtl/mips_multi.sv | 264 ++++++++++++++++++++++++++
 tb/tb_mips_multi.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multi.sv
// Multicycle MIPS core: one shared ALU and one unified memory port, driven by a
// control FSM with a memready handshake on fetch, load and store.
module mips_multi #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter bit          ZEXT_LOGIC = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] memaddr,
    output logic        memread,
    output logic        memwrite,
    output logic [31:0] writedata,
    input  logic [31:0] readdata,
    input  logic        memready,
    output logic [31:0] pc,
    output logic        halted
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
        S_ALUWB, S_IEXEC, S_IWB, S_BRANCH, S_JUMP, S_HALT
    } state_t;

    state_t      state;
    logic [31:0] pc_r, ir, mdr, a, b, aluout;
    logic        rd_q, wr_q, halted_q;
    logic [31:0] rf [32];

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd;
    logic [31:0] signimm, zeroimm, logicimm;
    logic [31:0] rf_a, rf_b;
    logic        r_ok;
    logic [2:0]  r_ctl;
    state_t      dec_next;
    logic [31:0] alu_x, alu_y, alu_res;
    logic [2:0]  alu_ctl;
    logic        zero, take;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;

    assign op       = ir[31:26];
    assign rs       = ir[25:21];
    assign rt       = ir[20:16];
    assign rd       = ir[15:11];
    assign funct    = ir[5:0];
    assign signimm  = {{16{ir[15]}}, ir[15:0]};
    assign zeroimm  = {16'h0000, ir[15:0]};
    assign logicimm = ZEXT_LOGIC ? zeroimm : signimm;
    assign rf_a     = (rs == 5'd0) ? '0 : rf[rs];
    assign rf_b     = (rt == 5'd0) ? '0 : rf[rt];

    always_comb begin
        r_ok  = 1'b1;
        r_ctl = ALU_ADD;
        case (funct)
            FN_ADD:  r_ctl = ALU_ADD;
            FN_SUB:  r_ctl = ALU_SUB;
            FN_AND:  r_ctl = ALU_AND;
            FN_OR:   r_ctl = ALU_OR;
            FN_SLT:  r_ctl = ALU_SLT;
            default: r_ok  = 1'b0;
        endcase
    end

    always_comb begin
        case (op)
            OP_RTYPE:                       dec_next = r_ok ? S_EXEC : S_HALT;
            OP_LW, OP_SW:                   dec_next = S_MEMADR;
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: dec_next = S_IEXEC;
            OP_BEQ, OP_BNE:                 dec_next = S_BRANCH;
            OP_J:                           dec_next = S_JUMP;
            default:                        dec_next = S_HALT;
        endcase
    end

    // Single shared ALU; its operands are steered by the current state.
    always_comb begin
        alu_x   = a;
        alu_y   = b;
        alu_ctl = ALU_ADD;
        case (state)
            S_FETCH: begin
                alu_x = pc_r;
                alu_y = 32'd4;
            end
            S_DECODE: begin
                alu_x = pc_r;
                alu_y = {signimm[29:0], 2'b00};
            end
            S_MEMADR: alu_y = signimm;
            S_EXEC:   alu_ctl = r_ctl;
            S_IEXEC: begin
                case (op)
                    OP_SLTI: begin
                        alu_ctl = ALU_SLT;
                        alu_y   = signimm;
                    end
                    OP_ANDI: begin
                        alu_ctl = ALU_AND;
                        alu_y   = logicimm;
                    end
                    OP_ORI: begin
                        alu_ctl = ALU_OR;
                        alu_y   = logicimm;
                    end
                    default: alu_y = signimm;
                endcase
            end
            S_BRANCH: alu_ctl = ALU_SUB;
            default: ;
        endcase
    end

    always_comb begin
        case (alu_ctl)
            ALU_AND: alu_res = alu_x & alu_y;
            ALU_OR:  alu_res = alu_x | alu_y;
            ALU_SUB: alu_res = alu_x - alu_y;
            ALU_SLT: alu_res = {31'd0, $signed(alu_x) < $signed(alu_y)};
            default: alu_res = alu_x + alu_y;
        endcase
    end

    assign zero = (alu_res == '0);
    assign take = ((op == OP_BEQ) && zero) || ((op == OP_BNE) && !zero);

    always_comb begin
        rf_we = 1'b0;
        rf_wa = rt;
        rf_wd = aluout;
        case (state)
            S_MEMWB: begin
                rf_we = 1'b1;
                rf_wd = mdr;
            end
            S_ALUWB: begin
                rf_we = 1'b1;
                rf_wa = rd;
            end
            S_IWB:   rf_we = 1'b1;
            default: ;
        endcase
    end

    // Register file is deliberately left uncleared by reset.
    always_ff @(posedge clk) begin
        if (reset && rf_we && (rf_wa != 5'd0))
            rf[rf_wa] <= rf_wd;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= S_FETCH;
            pc_r     <= RESET_PC;
            ir       <= '0;
            mdr      <= '0;
            a        <= '0;
            b        <= '0;
            aluout   <= '0;
            rd_q     <= 1'b1;
            wr_q     <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            case (state)
                S_FETCH: if (memready) begin
                    ir    <= readdata;
                    pc_r  <= alu_res;
                    rd_q  <= 1'b0;
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    a      <= rf_a;
                    b      <= rf_b;
                    aluout <= alu_res;
                    state  <= dec_next;
                    if (dec_next == S_HALT)
                        halted_q <= 1'b1;
                end
                S_MEMADR: begin
                    aluout <= alu_res;
                    if (op == OP_LW) begin
                        rd_q  <= 1'b1;
                        state <= S_MEMRD;
                    end else begin
                        wr_q  <= 1'b1;
                        state <= S_MEMWR;
                    end
                end
                S_MEMRD: if (memready) begin
                    mdr   <= readdata;
                    rd_q  <= 1'b0;
                    state <= S_MEMWB;
                end
                S_MEMWR: if (memready) begin
                    wr_q  <= 1'b0;
                    rd_q  <= 1'b1;
                    state <= S_FETCH;
                end
                S_EXEC: begin
                    aluout <= alu_res;
                    state  <= S_ALUWB;
                end
                S_IEXEC: begin
                    aluout <= alu_res;
                    state  <= S_IWB;
                end
                S_BRANCH: begin
                    if (take)
                        pc_r <= aluout;
                    rd_q  <= 1'b1;
                    state <= S_FETCH;
                end
                S_JUMP: begin
                    pc_r  <= {pc_r[31:28], ir[25:0], 2'b00};
                    rd_q  <= 1'b1;
                    state <= S_FETCH;
                end
                S_MEMWB, S_ALUWB, S_IWB: begin
                    rd_q  <= 1'b1;
                    state <= S_FETCH;
                end
                S_HALT: ;
                default: begin
                    halted_q <= 1'b1;
                    state    <= S_HALT;
                end
            endcase
        end
    end

    // Requests are gated by reset so an in-flight store is dropped the cycle reset hits.
    assign memread   = rd_q & reset;
    assign memwrite  = wr_q & reset;
    assign memaddr   = (state == S_FETCH) ? pc_r : aluout;
    assign writedata = b;
    assign pc        = pc_r;
    assign halted    = halted_q;

endmodule

// File: tb/tb_mips_multi.sv
// Bench for mips_multi: two cores (zero- and sign-extending logic immediates)
// run the same programs in lockstep; stores are checked against a scoreboard.
module tb_mips_multi;

    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_SLTI = 6'h0A;
    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [31:0] ILL    = 32'hFC00_0000;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        string       name;
        logic [31:0] i0, i1, i2;
        logic [31:0] ez, es;
    } vec_t;

    logic        clk = 1'b0, reset = 1'b0, memready = 1'b1;
    logic [31:0] memaddr0, writedata0, readdata0, pc0;
    logic [31:0] memaddr1, writedata1, readdata1, pc1;
    logic        memread0, memwrite0, halted0;
    logic        memread1, memwrite1, halted1;
    logic [31:0] mem [1024];

    assign readdata0 = mem[memaddr0[11:2]];
    assign readdata1 = mem[memaddr1[11:2]];

    mips_multi #(.RESET_PC(32'h100), .ZEXT_LOGIC(1'b1)) u_z (
        .clk(clk), .reset(reset), .memaddr(memaddr0), .memread(memread0),
        .memwrite(memwrite0), .writedata(writedata0), .readdata(readdata0),
        .memready(memready), .pc(pc0), .halted(halted0)
    );

    mips_multi #(.RESET_PC(32'h100), .ZEXT_LOGIC(1'b0)) u_s (
        .clk(clk), .reset(reset), .memaddr(memaddr1), .memread(memread1),
        .memwrite(memwrite1), .writedata(writedata1), .readdata(readdata1),
        .memready(memready), .pc(pc1), .halted(halted1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_pass = 0, n_total = 0, viol = 0, wr_cyc = 0, log_n = 0;
    logic [31:0] log_addr [64];
    int          log_cyc  [64];
    wr_t         q0 [$], q1 [$];
    vec_t        vecs [$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic wr_t mkwr(input logic [31:0] addr, input logic [31:0] data);
        wr_t e;
        e.addr = addr;
        e.data = data;
        return e;
    endfunction

    // Monitor: logs completed reads of the first core and scores every store.
    initial forever begin
        wr_t e;
        @(negedge clk);
        if (!reset) begin
            log_n = 0;
        end else begin
            if ((memread0 && memwrite0) || (memread1 && memwrite1)) viol++;
            if (memread0 && memready && log_n < 64) begin
                log_addr[log_n] = memaddr0;
                log_cyc[log_n]  = cyc;
                log_n++;
            end
            if (memwrite0 && memready) begin
                wr_cyc = cyc;
                if (q0.size() == 0) begin
                    n_total++;
                    $display("FAIL wr_z: unexpected write addr %h data %h, expected none", memaddr0, writedata0);
                end else begin
                    e = q0.pop_front();
                    chk("wr_z_addr", memaddr0, e.addr);
                    chk("wr_z_data", writedata0, e.data);
                end
            end
            if (memwrite1 && memready) begin
                if (q1.size() == 0) begin
                    n_total++;
                    $display("FAIL wr_s: unexpected write addr %h data %h, expected none", memaddr1, writedata1);
                end else begin
                    e = q1.pop_front();
                    chk("wr_s_addr", memaddr1, e.addr);
                    chk("wr_s_data", writedata1, e.data);
                end
            end
        end
    end

    task automatic load_blank();
        for (int i = 0; i < 1024; i++) mem[i] = ILL;
    endtask

    task automatic put(input logic [31:0] addr, input logic [31:0] w);
        mem[addr[11:2]] = w;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        reset    = 1'b0;
        memready = 1'b1;
        step();
        step();
    endtask

    task automatic wait_halt(input int budget, input logic [31:0] exp_pc, input string tag);
        int k = 0;
        while (!(halted0 && halted1) && k < budget) begin
            step();
            k++;
        end
        chk({tag, "_halted"}, 32'(halted0 & halted1), 32'd1);
        chk({tag, "_pc"}, pc0, exp_pc);
        chk({tag, "_sb_empty"}, 32'(q0.size() + q1.size()), 32'd0);
    endtask

    initial begin
        int t0, n_rd;

        vecs.push_back('{"ori_ext", itype(OP_ADDI,0,2,16'd5), itype(OP_ORI,2,3,16'hF000), rtype(3,0,5,6'h20), 32'h0000_F005, 32'hFFFF_F005});
        vecs.push_back('{"add_neg", itype(OP_ADDI,0,1,16'd7), itype(OP_ADDI,0,2,16'hFFFD), rtype(1,2,5,6'h20), 32'd4, 32'd4});
        vecs.push_back('{"sub", itype(OP_ADDI,0,1,16'd3), itype(OP_ADDI,0,2,16'd5), rtype(1,2,5,6'h22), 32'hFFFF_FFFE, 32'hFFFF_FFFE});
        vecs.push_back('{"slt_t", itype(OP_ADDI,0,1,16'hFFFF), itype(OP_ADDI,0,2,16'd1), rtype(1,2,5,6'h2A), 32'd1, 32'd1});
        vecs.push_back('{"slt_f", itype(OP_ADDI,0,1,16'd1), itype(OP_ADDI,0,2,16'hFFFF), rtype(1,2,5,6'h2A), 32'd0, 32'd0});
        vecs.push_back('{"andi_ext", itype(OP_ADDI,0,1,16'hFFFF), itype(OP_ANDI,1,5,16'h8001), rtype(1,1,0,6'h20), 32'h0000_8001, 32'hFFFF_8001});
        vecs.push_back('{"slti", itype(OP_ADDI,0,1,16'hFFFB), itype(OP_SLTI,1,5,16'hFFFC), rtype(0,0,0,6'h20), 32'd1, 32'd1});
        vecs.push_back('{"r0_wr", itype(OP_ADDI,0,0,16'd9), itype(OP_ADDI,0,1,16'd3), rtype(0,1,5,6'h20), 32'd3, 32'd3});
        vecs.push_back('{"and", itype(OP_ADDI,0,1,16'h0F0F), itype(OP_ADDI,0,2,16'h00FF), rtype(1,2,5,6'h24), 32'h0000_000F, 32'h0000_000F});
        vecs.push_back('{"or", itype(OP_ADDI,0,1,16'h0F0F), itype(OP_ADDI,0,2,16'h00FF), rtype(1,2,5,6'h25), 32'h0000_0FFF, 32'h0000_0FFF});
        vecs.push_back('{"wrap", itype(OP_ADDI,0,1,16'hFFFF), itype(OP_ADDI,0,2,16'd1), rtype(1,2,5,6'h20), 32'd0, 32'd0});

        // Reset: no requests while held, first fetch at RESET_PC on release.
        load_blank();
        step();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_memread", 32'(memread0), 32'd0);
            chk("rst_memwrite", 32'(memwrite0), 32'd0);
            step();
        end
        reset = 1'b1;
        @(negedge clk);
        chk("rst_fetch_addr", memaddr0, 32'h100);
        chk("rst_fetch_rd", 32'(memread0), 32'd1);
        wait_halt(20, 32'h104, "rst");

        // Table of short programs, each ending in sw $5,0x200($0) and an illegal op.
        for (int i = 0; i < vecs.size(); i++) begin
            load_blank();
            put(32'h100, vecs[i].i0);
            put(32'h104, vecs[i].i1);
            put(32'h108, vecs[i].i2);
            put(32'h10C, itype(OP_SW, 0, 5, 16'h0200));
            do_reset();
            q0.push_back(mkwr(32'h200, vecs[i].ez));
            q1.push_back(mkwr(32'h200, vecs[i].es));
            reset = 1'b1;
            wait_halt(60, 32'h114, vecs[i].name);
        end

        // Store lands in the 12th cycle counted from the first fetch.
        load_blank();
        put(32'h100, itype(OP_ADDI, 0, 2, 16'd5));
        put(32'h104, itype(OP_ORI, 2, 3, 16'hF000));
        put(32'h108, itype(OP_SW, 0, 3, 16'd84));
        do_reset();
        q0.push_back(mkwr(32'd84, 32'h0000_F005));
        q1.push_back(mkwr(32'd84, 32'hFFFF_F005));
        reset = 1'b1;
        t0 = cyc;
        wait_halt(60, 32'h110, "sw_time");
        chk("sw_time_cycle", 32'(wr_cyc - t0), 32'd11);

        // Taken beq skips two words, untaken bne falls through; 3 cycles each.
        load_blank();
        put(32'h100, itype(OP_ADDI, 0, 2, 16'd5));
        put(32'h104, itype(OP_BEQ, 2, 2, 16'd2));
        put(32'h110, itype(OP_BNE, 2, 2, 16'd2));
        put(32'h114, itype(OP_ADDI, 0, 5, 16'h0077));
        put(32'h118, itype(OP_SW, 0, 5, 16'h0200));
        do_reset();
        q0.push_back(mkwr(32'h200, 32'h77));
        q1.push_back(mkwr(32'h200, 32'h77));
        reset = 1'b1;
        t0 = cyc;
        wait_halt(60, 32'h120, "br");
        chk("beq_target", log_addr[2], 32'h110);
        chk("beq_cycles", 32'(log_cyc[2] - t0), 32'd7);
        chk("bne_target", log_addr[3], 32'h114);
        chk("bne_cycles", 32'(log_cyc[3] - t0), 32'd10);

        // Load with three wait cycles, then store of the loaded value.
        load_blank();
        put(32'h000, 32'hDEAD_BEEF);
        put(32'h100, itype(OP_LW, 0, 4, 16'd0));
        put(32'h104, itype(OP_SW, 0, 4, 16'h0200));
        do_reset();
        q0.push_back(mkwr(32'h200, 32'hDEAD_BEEF));
        q1.push_back(mkwr(32'h200, 32'hDEAD_BEEF));
        reset = 1'b1;
        t0 = cyc;
        repeat (3) step();
        memready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("lw_stall_addr", memaddr0, 32'h0);
            chk("lw_stall_rd", 32'(memread0), 32'd1);
            step();
        end
        memready = 1'b1;
        wait_halt(40, 32'h10C, "lw_stall");
        chk("lw_data_addr", log_addr[1], 32'h0);
        chk("lw_next_fetch", log_addr[2], 32'h104);
        chk("lw_cycles", 32'(log_cyc[2] - t0), 32'd8);

        // Jump to an illegal opcode at 0x20, halt, then recover through reset.
        load_blank();
        put(32'h100, {6'h02, 26'h000_0008});
        do_reset();
        reset = 1'b1;
        t0 = cyc;
        repeat (4) step();
        @(negedge clk);
        chk("halt_early", 32'(halted0), 32'd0);
        step();
        @(negedge clk);
        chk("halt_rise", 32'(halted0 & halted1), 32'd1);
        chk("halt_pc", pc0, 32'h24);
        chk("halt_fetch_addr", log_addr[1], 32'h20);
        chk("halt_fetch_cyc", 32'(log_cyc[1] - t0), 32'd3);
        n_rd = 0;
        repeat (10) begin
            @(negedge clk);
            n_rd += int'(memread0 | memread1);
        end
        chk("halt_no_read", 32'(n_rd), 32'd0);
        do_reset();
        chk("halt_rst_clear", 32'(halted0 | halted1), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("halt_refetch_addr", memaddr0, 32'h100);
        chk("halt_refetch_rd", 32'(memread0), 32'd1);
        wait_halt(30, 32'h24, "halt_again");

        // Reset during a stalled store: the store is dropped, then replayed from RESET_PC.
        load_blank();
        put(32'h100, itype(OP_SW, 0, 0, 16'h0200));
        do_reset();
        reset = 1'b1;
        repeat (3) step();
        memready = 1'b0;
        @(negedge clk);
        chk("memwr_pending", 32'(memwrite0), 32'd1);
        step();
        reset    = 1'b0;
        memready = 1'b1;
        @(negedge clk);
        chk("memwr_rst_z", 32'(memwrite0), 32'd0);
        chk("memwr_rst_s", 32'(memwrite1), 32'd0);
        step();
        step();
        q0.push_back(mkwr(32'h200, 32'h0));
        q1.push_back(mkwr(32'h200, 32'h0));
        reset = 1'b1;
        @(negedge clk);
        chk("memwr_refetch_addr", memaddr0, 32'h100);
        chk("memwr_refetch_rd", 32'(memread0), 32'd1);
        chk("memwr_refetch_wr", 32'(memwrite0), 32'd0);
        wait_halt(30, 32'h108, "memwr_rst");

        chk("rd_wr_exclusive", 32'(viol), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
